// File: rtl/plane_sprite_drawer.sv
// Sprite expander: turns one plane anchor into an SPR_W x SPR_H per-pixel VGA write stream.
// Optional screen-edge clipping is enabled by defining SPRITE_CLIP_EN.
module plane_sprite_drawer #(
  parameter int                     SPR_W     = 4,
  parameter int                     SPR_H     = 4,
  parameter logic [SPR_W*SPR_H-1:0] SPR_MASK  = 16'h6FF6,
  parameter logic [2:0]             BG_COLOUR = 3'b000,
  parameter int                     SCR_W     = 160,
  parameter int                     SCR_H     = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [7:0] req_y,
  input  logic [2:0] req_colour,
  input  logic       req_erase,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       draw_done
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int IDX_W = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPR_H - 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t state, state_next;

  logic [7:0]       act_x, act_y, pend_x, pend_y;
  logic [2:0]       act_colour, pend_colour;
  logic             act_erase, pend_erase;
  logic             pend_full;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic xfer, last_pix, load_req, load_pend, fill_pend;

  assign req_ready = ~pend_full;
  assign xfer      = req_valid & req_ready;
  assign last_pix  = (state == DRAW) && (col == COL_MAX) && (row == ROW_MAX);
  // A transfer on the last pixel with an empty slot bypasses straight into the active set.
  assign load_req  = xfer & ((state == IDLE) | last_pix);
  assign load_pend = last_pix & pend_full;
  assign fill_pend = xfer & (state == DRAW) & ~last_pix;
  assign busy      = (state == DRAW) | draw_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (xfer) state_next = DRAW;
      DRAW: if (last_pix && !pend_full && !xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: payload registers carry no reset; pend_full and state qualify their contents.
  always_ff @(posedge clk) begin
    if (load_pend) begin
      act_x      <= pend_x;
      act_y      <= pend_y;
      act_colour <= pend_colour;
      act_erase  <= pend_erase;
    end else if (load_req) begin
      act_x      <= req_x;
      act_y      <= req_y;
      act_colour <= req_colour;
      act_erase  <= req_erase;
    end
    if (fill_pend) begin
      pend_x      <= req_x;
      pend_y      <= req_y;
      pend_colour <= req_colour;
      pend_erase  <= req_erase;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_full <= 1'b0;
      col       <= '0;
      row       <= '0;
    end else begin
      if (fill_pend)      pend_full <= 1'b1;
      else if (load_pend) pend_full <= 1'b0;

      if (last_pix || load_req) begin
        col <= '0;
        row <= '0;
      end else if (state == DRAW) begin
        if (col == COL_MAX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  logic [7:0]       pix_x, pix_y;
  logic             pix_clip, pix_plot;
  logic [IDX_W-1:0] pix_idx;

  assign pix_idx = IDX_W'(int'(row) * SPR_W + int'(col));

`ifdef SPRITE_CLIP_EN
  logic [8:0] sum_x, sum_y;
  assign sum_x    = {1'b0, act_x} + 9'(col);
  assign sum_y    = {1'b0, act_y} + 9'(row);
  assign pix_x    = sum_x[7:0];
  assign pix_y    = sum_y[7:0];
  assign pix_clip = (sum_x >= 9'(SCR_W)) || (sum_y >= 9'(SCR_H));
`else
  assign pix_x    = act_x + 8'(col);
  assign pix_y    = act_y + 8'(row);
  assign pix_clip = 1'b0;
`endif

  assign pix_plot = (act_erase | SPR_MASK[pix_idx]) & ~pix_clip;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      draw_done  <= 1'b0;
    end else if (state == DRAW) begin
      vga_x      <= pix_x;
      vga_y      <= pix_y;
      vga_colour <= act_erase ? BG_COLOUR : act_colour;
      vga_plot   <= pix_plot;
      draw_done  <= last_pix;
    end else begin
      vga_plot   <= 1'b0;
      draw_done  <= 1'b0;
    end
  end

endmodule
